wave_seq_ctrl: RTL and testbench
================================

// Module: wave_seq_ctrl
// PURPOSE
//  Sequencer for the byte-pattern waveform datapath (16x8 async-read pattern memory + 8:1 bit select).
//  Replaces the free-running counter chain with a start/stop controlled FSM.
//  Walks memory addresses 0..last_addr and serialises each byte LSB-first onto wave_out, gapless across bytes.
//  Supports one-shot or looping playback.
//  Sits between the pattern memory (drives its addr, consumes its data) and the waveform consumer.
// PARAMETERS
//  DEPTH  16  pattern entries; AW = $clog2(DEPTH) = 4
//  WIDTH   8  bits per entry; BW = $clog2(WIDTH) = 3
// PORTS
//  clk        in   1      single clock, all state on posedge
//  clear_n    in   1      asynchronous, active-low reset
//  start      in   1      level-sampled request; honoured only in IDLE
//  stop       in   1      abort; honoured in any non-IDLE state
//  loop       in   1      sampled with start: 1 = repeat pattern until stop
//  last_addr  in   AW     sampled with start: index of final entry (N = last_addr+1 bytes)
//  mem_addr   out  AW     address to pattern memory (combinational read, data valid same cycle)
//  mem_data   in   WIDTH  pattern byte at mem_addr
//  bit_sel    out  BW     index of bit currently on wave_out
//  wave_out   out  1      serial waveform; 0 whenever not in SHIFT
//  busy       out  1      1 in LOAD/SHIFT(/PAR)
//  done       out  1      one-cycle pulse after the final bit of a one-shot run
// BEHAVIOUR
//  Reset (clear_n=0, async): state=IDLE, mem_addr=0, bit_sel=0, byte_reg=0,
//   len_q=0, loop_q=0; outputs wave_out=0, busy=0, done=0.
//  IDLE:  start=1 & stop=0 -> capture last_addr/loop, mem_addr<=0, -> LOAD. start & stop together: stay IDLE.
//  LOAD (1 cycle, busy=1, wave_out=0): byte_reg<=mem_data; mem_addr<=next(0); bit_sel<=0; -> SHIFT.
//  SHIFT: wave_out=byte_reg[bit_sel]; bit_sel++ each cycle.
//   At bit_sel==WIDTH-1, the byte just sent was entry last_addr if mem_addr wrapped (prefetch pointer):
//   - more bytes: byte_reg<=mem_data, mem_addr<=next, bit_sel<=0, stay SHIFT (no bubble).
//   - final byte, loop_q=1: reload entry 0 identically (mem_addr already 0), stay SHIFT.
//   - final byte, loop_q=0: -> DONE.
//  next(a) = (a==len_q) ? 0 : a+1; mem_addr always points to the byte after byte_reg.
//  DONE (1 cycle): done=1, busy=0, wave_out=0, mem_addr<=0 -> IDLE.
//  Latency: start sampled at edge k -> LOAD in cycle k+1 -> bit0 of entry 0 in cycle k+2.
//  One-shot length: exactly 8*N SHIFT cycles; done in cycle k+2+8N.
//  stop while busy: -> IDLE next edge, wave_out=0 from then, no done pulse; stop beats start.
//  start while busy ignored; last_addr/loop changes mid-run ignored until next start.
//  last_addr=0: single byte repeated (loop) or sent once.
// CONFIGURATION
//  WAVE_SEQ_PARITY_EN defined:
//   - after bit WIDTH-1 of each byte, state PAR (1 cycle, busy=1);
//   - wave_out = even parity (^byte_reg), bit_sel holds WIDTH-1;
//   - byte reload/DONE decision moves to PAR exit; 9 cycles per byte, done at k+2+9N.
//  Undefined: no PAR state, 8 cycles per byte as above.
// STRUCTURE
//  wave_seq_pkg: state enum (IDLE, LOAD, SHIFT, PAR, DONE), DEPTH/WIDTH defaults, AW/BW localparam functions.
//  Sub-module wave_bit_shifter: byte_reg + bit_sel counter + output select
//   (load, adv, byte_last flag); FSM and address pointer stay in wave_seq_ctrl.
// TESTING (memory pattern: even addr 0xCC, odd addr 0xAA)
//  1 Reset mid-SHIFT: clear_n low async -> wave_out/busy/done/mem_addr/bit_sel 0 same cycle, IDLE after release.
//  2 One-shot, last_addr=1, loop=0, start 1 cycle
//    -> LOAD, then wave_out 0,0,1,1,0,0,1,1, 0,1,0,1,0,1,0,1
//    -> done pulse exactly 18 cycles after start edge, busy low.
//  3 loop=1, last_addr=0
//    -> 0xCC pattern repeats with no gap for 40 cycles
//    -> stop asserted -> IDLE next edge, wave_out=0, no done.
//  4 start held high through a one-shot run -> second run begins right after DONE, start pulses while busy ignored.
//  5 start&stop same cycle in IDLE -> stays IDLE.
//    last_addr=15 one-shot -> mem_addr sequence 1..15,0, done at 2+128.
//  6 WAVE_SEQ_PARITY_EN build, last_addr=1
//    -> parity bit 0 after 0xCC and 0 after 0xAA
//    -> done at 2+18 cycles.

Source files
------------

// File: rtl/wave_seq_pkg.sv
// rtl/wave_seq_pkg.sv - state type and sizing helpers for the byte-pattern waveform sequencer
package wave_seq_pkg;

  localparam int WS_DEPTH = 16;
  localparam int WS_WIDTH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_PAR,
    S_DONE
  } ws_state_e;

  function automatic int ws_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int ws_bw(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/wave_bit_shifter.sv
// rtl/wave_bit_shifter.sv - holds the current pattern byte and selects the bit (or parity) driven onto wave_out
module wave_bit_shifter
  import wave_seq_pkg::*;
#(
  parameter int WIDTH = WS_WIDTH,
  parameter int BW    = ws_bw(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] data,
  input  logic             show_bit,
  input  logic             show_par,
  output logic [BW-1:0]    bit_sel,
  output logic             byte_last,
  output logic             wave_out
);

  logic [WIDTH-1:0] byte_reg;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      byte_reg <= '0;
      bit_sel  <= '0;
    end else if (load) begin
      byte_reg <= data;
      bit_sel  <= '0;
    end else if (adv) begin
      bit_sel <= bit_sel + BW'(1);
    end
  end

  assign byte_last = (bit_sel == BW'(WIDTH - 1));
  assign wave_out  = (show_bit & byte_reg[bit_sel]) | (show_par & (^byte_reg));

endmodule

// File: rtl/wave_seq_ctrl.sv
// rtl/wave_seq_ctrl.sv - start/stop sequencer walking pattern memory and serialising bytes LSB-first
// Optional per-byte even parity bit when WAVE_SEQ_PARITY_EN is defined.
module wave_seq_ctrl
  import wave_seq_pkg::*;
#(
  parameter int DEPTH = WS_DEPTH,
  parameter int WIDTH = WS_WIDTH,
  parameter int AW    = ws_aw(DEPTH),
  parameter int BW    = ws_bw(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic [AW-1:0]    last_addr,
  output logic [AW-1:0]    mem_addr,
  input  logic [WIDTH-1:0] mem_data,
  output logic [BW-1:0]    bit_sel,
  output logic             wave_out,
  output logic             busy,
  output logic             done
);

  ws_state_e     state;
  logic [AW-1:0] len_q;
  logic [AW-1:0] next_addr;
  logic          loop_q;
  logic          byte_last;
  logic          decide;
  logic          more;
  logic          sh_load;
  logic          sh_adv;

  // mem_addr is a prefetch pointer: it reads back 0 once the final entry has been taken
  assign next_addr = (mem_addr == len_q) ? '0 : mem_addr + AW'(1);
  assign more      = (mem_addr != '0) || loop_q;

`ifdef WAVE_SEQ_PARITY_EN
  assign decide = (state == S_PAR);
`else
  assign decide = (state == S_SHIFT) && byte_last;
`endif

  assign sh_load = !stop && ((state == S_LOAD) || (decide && more));
  assign sh_adv  = !stop && (state == S_SHIFT) && !byte_last;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= S_IDLE;
      mem_addr <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && (state != S_IDLE)) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        mem_addr <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              len_q    <= last_addr;
              loop_q   <= loop;
              mem_addr <= '0;
              busy     <= 1'b1;
              state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            mem_addr <= next_addr;
            state    <= S_SHIFT;
          end
          S_SHIFT: begin
`ifdef WAVE_SEQ_PARITY_EN
            if (byte_last) state <= S_PAR;
`endif
          end
          S_PAR: state <= S_SHIFT;
          S_DONE: begin
            mem_addr <= '0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
        // End of a byte: reload without a bubble, or finish a one-shot run
        if (decide) begin
          if (more) begin
            mem_addr <= next_addr;
          end else begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      end
    end
  end

  wave_bit_shifter #(
    .WIDTH (WIDTH),
    .BW    (BW)
  ) u_shifter (
    .clk       (clk),
    .clear_n   (clear_n),
    .load      (sh_load),
    .adv       (sh_adv),
    .data      (mem_data),
    .show_bit  (state == S_SHIFT),
    .show_par  (state == S_PAR),
    .bit_sel   (bit_sel),
    .byte_last (byte_last),
    .wave_out  (wave_out)
  );

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb/tb_wave_seq_ctrl.sv - randomized self-checking bench for wave_seq_ctrl against a bit-stream model
module tb_wave_seq_ctrl;

`ifdef WAVE_SEQ_PARITY_EN
  localparam int B = 9;
`else
  localparam int B = 8;
`endif

  logic       clk = 1'b0;
  logic       clear_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop = 1'b0;
  logic [3:0] last_addr = 4'd0;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic [2:0] bit_sel;
  logic       wave_out;
  logic       busy;
  logic       done;

  logic [7:0] mem [16];
  bit         exp_q[$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  wave_seq_ctrl dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .last_addr (last_addr),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .bit_sel   (bit_sel),
    .wave_out  (wave_out),
    .busy      (busy),
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pattern();
    for (int a = 0; a < 16; a++) mem[a] = a[0] ? 8'hAA : 8'hCC;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
  endtask

  // Expected serial stream of one pass: entries 0..last, LSB first, optional parity bit
  task automatic build(input int last);
    exp_q.delete();
    for (int b = 0; b <= last; b++) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(mem[b][i]);
      if (B == 9) exp_q.push_back(^mem[b]);
    end
  endtask

  task automatic play(input int last, input bit hold);
    int n;
    int exp_a;
    build(last);
    n = exp_q.size();
    start = 1'b1; stop = 1'b0; loop = 1'b0; last_addr = 4'(last);
    tick();
    if (!hold) start = 1'b0;
    last_addr = 4'($urandom);
    loop = 1'($urandom);
    checks++;
    if ({busy, done, wave_out} !== 3'b100) begin
      errors++;
      $display("FAIL load_state last=%0d: busy/done/wave=%b want 100", last, {busy, done, wave_out});
    end
    for (int i = 0; i < n; i++) begin
      tick();
      if (!hold) start = 1'($urandom);
      checks++;
      if ({busy, done, wave_out} !== {2'b10, exp_q[i]}) begin
        errors++;
        $display("FAIL oneshot_bit%0d last=%0d: busy/done/wave=%b want %b", i, last,
                 {busy, done, wave_out}, {2'b10, exp_q[i]});
      end
      if (i % B == 0) begin
        exp_a = (i / B == last) ? 0 : i / B + 1;
        checks++;
        if (mem_addr !== 4'(exp_a)) begin
          errors++;
          $display("FAIL mem_addr byte%0d last=%0d: got %0d want %0d", i / B, last, mem_addr, exp_a);
        end
      end
    end
    tick();
    start = hold;
    checks++;
    if ({busy, done, wave_out} !== 3'b010) begin
      errors++;
      $display("FAIL done_pulse last=%0d: busy/done/wave=%b want 010", last, {busy, done, wave_out});
    end
    tick();
    checks++;
    if ({busy, done, wave_out, mem_addr} !== 7'b000_0000) begin
      errors++;
      $display("FAIL idle_after_done last=%0d: busy/done/wave/addr=%b want 0000000", last,
               {busy, done, wave_out, mem_addr});
    end
  endtask

  task automatic play_loop(input int last, input int cycles);
    int n;
    build(last);
    n = exp_q.size();
    start = 1'b1; stop = 1'b0; loop = 1'b1; last_addr = 4'(last);
    tick();
    start = 1'b0; loop = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      start = 1'($urandom);
      checks++;
      if ({busy, done, wave_out} !== {2'b10, exp_q[i % n]}) begin
        errors++;
        $display("FAIL loop_bit%0d last=%0d: busy/done/wave=%b want %b", i, last,
                 {busy, done, wave_out}, {2'b10, exp_q[i % n]});
      end
    end
    start = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({busy, done, wave_out} !== 3'b000) begin
        errors++;
        $display("FAIL after_stop%0d last=%0d: busy/done/wave=%b want 000", j, last, {busy, done, wave_out});
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #2 clear_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({wave_out, busy, done, mem_addr, bit_sel} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: wave/busy/done/addr/sel=%b want 0", {wave_out, busy, done, mem_addr, bit_sel});
    end
    clear_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    fill_pattern();
    start = 1'b1; loop = 1'b0; last_addr = 4'd1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({busy, bit_sel} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL pre_reset_shift: busy/sel=%b want 1010", {busy, bit_sel});
    end
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if ({wave_out, busy, done, mem_addr, bit_sel} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: wave/busy/done/addr/sel=%b want 0", {wave_out, busy, done, mem_addr, bit_sel});
    end
    tick();
    clear_n = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, wave_out, mem_addr} !== 7'd0) begin
      errors++;
      $display("FAIL idle_after_reset: busy/done/wave/addr=%b want 0", {busy, done, wave_out, mem_addr});
    end
  endtask

  task automatic test_oneshot();
    fill_pattern();
    play(1, 1'b0);
    play(0, 1'b0);
    for (int r = 0; r < 4; r++) begin
      fill_random();
      play(int'($urandom_range(0, 15)), 1'b0);
    end
  endtask

  task automatic test_loop();
    fill_pattern();
    play_loop(0, 40);
    for (int r = 0; r < 3; r++) begin
      fill_random();
      play_loop(int'($urandom_range(0, 15)), int'($urandom_range(20, 200)));
    end
  endtask

  task automatic test_back_to_back();
    fill_pattern();
    play(1, 1'b1);
    play(0, 1'b0);
  endtask

  task automatic test_start_stop();
    fill_pattern();
    start = 1'b1; stop = 1'b1; last_addr = 4'd3;
    tick();
    start = 1'b0; stop = 1'b0;
    for (int j = 0; j < 2; j++) begin
      checks++;
      if ({busy, done, wave_out} !== 3'b000) begin
        errors++;
        $display("FAIL start_stop_idle%0d: busy/done/wave=%b want 000", j, {busy, done, wave_out});
      end
      tick();
    end
    play(15, 1'b0);
  endtask

  initial begin
    fill_pattern();
    test_reset();
    test_reset_mid_shift();
    test_oneshot();
    test_loop();
    test_back_to_back();
    test_start_stop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
